// File: rtl/wb_queue_pkg.sv
// Shared definitions for the writeback queue: default geometry, entry width
// and the register-number to one-hot decode used for reservation release.
package wb_queue_pkg;

  localparam int WBQ_DEPTH    = 4;
  localparam int WBQ_NREG     = 4;
  localparam int WBQ_REGNO_W  = 2;
  localparam int WBQ_DATA_W   = 32;
  localparam int WBQ_STALL_TH = 1;
  localparam int WBQ_ENTRY_W  = WBQ_REGNO_W + WBQ_DATA_W;

  function automatic logic [WBQ_NREG-1:0] regno_onehot(input logic [WBQ_REGNO_W-1:0] regno);
    return WBQ_NREG'(1) << regno;
  endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// Storage array for the writeback queue: synchronous write, asynchronous read.
module wb_fifo_mem
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int WIDTH = WBQ_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers {regno, data} results from execute and retires one
// per cycle onto the register-file write port, releasing the reservation.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH    = WBQ_DEPTH,
  parameter int NREG     = WBQ_NREG,
  parameter int REGNO_W  = WBQ_REGNO_W,
  parameter int DATA_W   = WBQ_DATA_W,
  parameter int STALL_TH = WBQ_STALL_TH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REGNO_W-1:0]       in_regno,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [NREG-1:0]          wb_reserved,
  output logic                     is_wb,
  output logic [REGNO_W-1:0]       wb_regno,
  output logic [NREG-1:0]          wb_exp,
  output logic [DATA_W-1:0]        data_o,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_unreserved
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = REGNO_W + DATA_W;

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] rd_entry;
  logic [REGNO_W-1:0] rd_regno;
  logic [DATA_W-1:0]  rd_data;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign stall    = ((DEPTH - int'(count)) <= STALL_TH);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0);
  assign {rd_regno, rd_data} = rd_entry;

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata ({in_regno, in_data}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer and occupancy tracking; full/empty derive from count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register slice plus sticky unreserved-write detection on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wb          <= 1'b0;
      wb_regno       <= '0;
      data_o         <= '0;
      err_unreserved <= 1'b0;
    end else begin
      is_wb <= pop;
      if (pop) begin
        wb_regno <= rd_regno;
        data_o   <= rd_data;
        if (!wb_reserved[rd_regno]) err_unreserved <= 1'b1;
      end
    end
  end

  // One-hot release strobe, qualified by the write enable.
  always_comb begin
    wb_exp = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      wb_exp[i] = is_wb && (wb_regno == REGNO_W'(i));
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_wb_queue;

  localparam int DEPTH    = 4;
  localparam int STALL_TH = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_regno;
  logic [31:0] in_data;
  logic [3:0]  wb_reserved;
  logic        is_wb;
  logic [1:0]  wb_regno;
  logic [3:0]  wb_exp;
  logic [31:0] data_o;
  logic        stall;
  logic [2:0]  count;
  logic        err_unreserved;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_is_wb;
  logic [1:0]  m_regno;
  logic [31:0] m_data;
  logic        m_err;

  wb_queue #(
    .DEPTH    (DEPTH),
    .NREG     (4),
    .REGNO_W  (2),
    .DATA_W   (32),
    .STALL_TH (STALL_TH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_regno       (in_regno),
    .in_data        (in_data),
    .wb_reserved    (wb_reserved),
    .is_wb          (is_wb),
    .wb_regno       (wb_regno),
    .wb_exp         (wb_exp),
    .data_o         (data_o),
    .stall          (stall),
    .count          (count),
    .err_unreserved (err_unreserved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the inputs currently applied.
  task automatic model_edge();
    ent_t e;
    bit   do_push;
    bit   do_pop;
    if (rst) begin
      q.delete();
      m_is_wb = 1'b0;
      m_regno = '0;
      m_data  = '0;
      m_err   = 1'b0;
      return;
    end
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = (q.size() > 0);
    m_is_wb = do_pop;
    if (do_pop) begin
      e       = q.pop_front();
      m_regno = e.r;
      m_data  = e.d;
      if (!wb_reserved[e.r]) m_err = 1'b1;
    end
    if (do_push) begin
      e.r = in_regno;
      e.d = in_data;
      q.push_back(e);
    end
  endtask

  task automatic compare_all(input string ph);
    logic [3:0] exp_onehot;
    int         free_slots;
    exp_onehot = m_is_wb ? (4'b0001 << m_regno) : 4'b0000;
    free_slots = DEPTH - q.size();
    chk({ph, ".is_wb"},    64'(is_wb),          64'(m_is_wb));
    chk({ph, ".wb_regno"}, 64'(wb_regno),       64'(m_regno));
    chk({ph, ".wb_exp"},   64'(wb_exp),         64'(exp_onehot));
    chk({ph, ".data_o"},   64'(data_o),         64'(m_data));
    chk({ph, ".count"},    64'(count),          64'(q.size()));
    chk({ph, ".in_ready"}, 64'(in_ready),       64'(q.size() != DEPTH));
    chk({ph, ".stall"},    64'(stall),          64'(free_slots <= STALL_TH));
    chk({ph, ".err"},      64'(err_unreserved), 64'(m_err));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic drive(input logic v, input logic [1:0] r, input logic [31:0] d);
    in_valid = v;
    in_regno = r;
    in_data  = d;
  endtask

  initial begin
    rst         = 1'b1;
    wb_reserved = 4'hF;
    drive(1'b0, 2'd0, 32'd0);
    m_is_wb = 1'b0; m_regno = '0; m_data = '0; m_err = 1'b0;

    // Reset
    cycle("rst");
    cycle("rst");
    chk("rst.is_wb_const",    64'(is_wb),          64'd0);
    chk("rst.count_const",    64'(count),          64'd0);
    chk("rst.in_ready_const", 64'(in_ready),       64'd1);
    chk("rst.stall_const",    64'(stall),          64'd0);
    chk("rst.err_const",      64'(err_unreserved), 64'd0);
    rst = 1'b0;
    cycle("idle");

    // Single write: two-edge latency, one-cycle pulse
    wb_reserved = 4'b0100;
    drive(1'b1, 2'd2, 32'hDEADBEEF);
    cycle("single.push");
    drive(1'b0, 2'd0, 32'd0);
    cycle("single.pop");
    chk("single.is_wb_const",  64'(is_wb),    64'd1);
    chk("single.regno_const",  64'(wb_regno), 64'd2);
    chk("single.exp_const",    64'(wb_exp),   64'h4);
    chk("single.data_const",   64'(data_o),   64'hDEADBEEF);
    cycle("single.after");
    chk("single.idle_const",   64'(is_wb),    64'd0);
    chk("single.count_const",  64'(count),    64'd0);

    // Back-to-back fill attempt
    wb_reserved = 4'hF;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 4), 32'h10 + 32'(i));
      cycle("fill");
    end
    drive(1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) cycle("fill.drain");

    // Streaming: occupancy stays at one
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'(i % 4), 32'h100 + 32'(i));
      cycle("stream");
      chk("stream.count_le1", 64'(count <= 3'd1), 64'd1);
    end
    drive(1'b0, 2'd0, 32'd0);
    cycle("stream.tail");
    chk("stream.last_data_const", 64'(data_o), 64'h109);
    cycle("stream.drain");

    // Unreserved write: flag rises, write still happens, flag is sticky
    wb_reserved = 4'b0000;
    drive(1'b1, 2'd3, 32'hCAFE0003);
    cycle("unres.push");
    drive(1'b0, 2'd0, 32'd0);
    cycle("unres.pop");
    chk("unres.err_const", 64'(err_unreserved), 64'd1);
    chk("unres.exp_const", 64'(wb_exp),         64'h8);
    wb_reserved = 4'hF;
    for (int i = 0; i < 3; i++) cycle("unres.hold");
    chk("unres.sticky_const", 64'(err_unreserved), 64'd1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 32'hA0 + 32'(i));
      cycle("midrst.fill");
    end
    rst = 1'b1;
    cycle("midrst.rst");
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'd0);
    chk("midrst.count_const", 64'(count),          64'd0);
    chk("midrst.is_wb_const", 64'(is_wb),          64'd0);
    chk("midrst.err_const",   64'(err_unreserved), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle("midrst.after");
      chk("midrst.no_stale", 64'(is_wb), 64'd0);
    end

    // Randomized traffic with occasional resets and reservation gaps
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      wb_reserved = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      drive($urandom_range(0, 9) < 7, 2'($urandom), $urandom);
      cycle("rand");
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) cycle("rand.drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
